// File: rtl/sal_ref_sched_pkg.sv
// Shared types and default sizing for the DDR2 per-bank auto-refresh scheduler.
package sal_ref_sched_pkg;

    localparam int unsigned NUM_BANKS_DEF    = 8;
    localparam int unsigned T_REFI_WIDTH_DEF = 16;
    localparam int unsigned T_GAP_WIDTH_DEF  = 4;
    localparam int unsigned MAX_POSTPONE_DEF = 8;
    localparam int unsigned URGENT_TH_DEF    = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/sal_ref_sched_if.sv
// Refresh request/grant handshake between the scheduler (master) and the bank controllers (slave).
interface sal_ref_sched_if #(
    parameter int unsigned NUM_BANKS = 8
) ();

    logic [NUM_BANKS-1:0] ref_req;
    logic [NUM_BANKS-1:0] ref_gnt;

    modport master (output ref_req, input ref_gnt);
    modport slave  (input ref_req, output ref_gnt);

endinterface

// File: rtl/sal_ref_sched_timing_cntr.sv
// Loadable down-counter that parks at zero; used for the inter-refresh gap.
module sal_ref_sched_timing_cntr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sal_ref_sched.sv
// Per-bank auto-refresh scheduler: tREFI time base, refresh debt tracking, round-robin requests.
// Optional pull-in (early refresh while idle, banked as credit) enabled by SAL_REF_PULL_IN_EN.
module sal_ref_sched
    import sal_ref_sched_pkg::*;
#(
    parameter int unsigned NUM_BANKS    = NUM_BANKS_DEF,
    parameter int unsigned T_REFI_WIDTH = T_REFI_WIDTH_DEF,
    parameter int unsigned T_GAP_WIDTH  = T_GAP_WIDTH_DEF,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEF,
    parameter int unsigned URGENT_TH    = URGENT_TH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ref_en_i,
    input  logic [T_REFI_WIDTH-1:0]               t_refi_m1_i,
    input  logic [T_GAP_WIDTH-1:0]                t_gap_m1_i,
    input  logic                                  idle_i,
    sal_ref_sched_if.master                       ref_if,
    output logic [$clog2(MAX_POSTPONE+1)-1:0]     debt_o,
    output logic                                  urgent_o,
    output logic                                  overflow_o
);

    localparam int unsigned DEBT_W = $clog2(MAX_POSTPONE + 1);
    localparam int unsigned PTR_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    state_e                  state_q, state_d;
    logic [NUM_BANKS-1:0]    req_q, req_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [T_REFI_WIDTH-1:0] refi_q, refi_d;
    logic [DEBT_W-1:0]       debt_q, debt_d;
    logic                    urgent_q;
    logic                    ovf_q, ovf_d;
    logic [T_GAP_WIDTH-1:0]  gap_cnt;
    logic                    tick_c, gnt_acc_c, want_c, gap_zero_c;

    assign tick_c     = ref_en_i && (refi_q == '0);
    assign gnt_acc_c  = (state_q == S_REQ) && ref_if.ref_gnt[ptr_q];
    assign gap_zero_c = (gap_cnt == '0);

    // Auto-reload interval timer; parked at the reload value while disabled.
    always_comb begin
        refi_d = refi_q - T_REFI_WIDTH'(1);
        if (!ref_en_i || tick_c) begin
            refi_d = t_refi_m1_i;
        end
    end

`ifdef SAL_REF_PULL_IN_EN
    logic [DEBT_W-1:0] credit_q, credit_d;

    // Debt and credit are mutually exclusive: a tick first spends credit, a grant first repays debt.
    always_comb begin
        debt_d   = debt_q;
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (tick_c && !gnt_acc_c) begin
            if (credit_q != '0) begin
                credit_d = credit_q - DEBT_W'(1);
            end else if (debt_q == DEBT_W'(MAX_POSTPONE)) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
        end else if (gnt_acc_c && !tick_c) begin
            if (debt_q != '0) begin
                debt_d = debt_q - DEBT_W'(1);
            end else if (credit_q != DEBT_W'(MAX_POSTPONE)) begin
                credit_d = credit_q + DEBT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign want_c = (debt_d != '0) ||
                    (idle_i && (credit_d != DEBT_W'(MAX_POSTPONE)));
`else
    logic unused_idle;

    always_comb begin
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick_c && !gnt_acc_c) begin
            if (debt_q == DEBT_W'(MAX_POSTPONE)) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_W'(1);
            end
        end else if (gnt_acc_c && !tick_c && (debt_q != '0)) begin
            debt_d = debt_q - DEBT_W'(1);
        end
    end

    assign unused_idle = idle_i;
    assign want_c      = (debt_d != '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refi_q   <= t_refi_m1_i;
            debt_q   <= '0;
            urgent_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            refi_q   <= refi_d;
            debt_q   <= debt_d;
            urgent_q <= (debt_d >= DEBT_W'(URGENT_TH));
            ovf_q    <= ovf_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next state; a grant on the pointed bank wins over a same-cycle disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ref_en_i && want_c) state_d = S_REQ;
            S_REQ: begin
                if (gnt_acc_c) begin
                    state_d = S_GAP;
                end else if (!ref_en_i) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_zero_c) begin
                    state_d = (ref_en_i && (debt_d != '0)) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the request is the one-hot pointer whenever the next state is REQ.
    always_comb begin
        ptr_d = ptr_q;
        req_d = '0;
        if (gnt_acc_c) begin
            ptr_d = (ptr_q == PTR_W'(NUM_BANKS - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
        if (state_d == S_REQ) begin
            req_d = NUM_BANKS'(1) << ptr_d;
        end
    end

    sal_ref_sched_timing_cntr #(
        .W (T_GAP_WIDTH)
    ) u_gap_cntr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gnt_acc_c),
        .load_val_i (t_gap_m1_i),
        .dec_i      (state_q == S_GAP),
        .cnt_o      (gap_cnt)
    );

    assign ref_if.ref_req = req_q;
    assign debt_o         = debt_q;
    assign urgent_o       = urgent_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_sal_ref_sched.sv
// Directed bench for sal_ref_sched; the pull-in scenario runs only when SAL_REF_PULL_IN_EN is defined.
module tb_sal_ref_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_en = 1'b0;
    logic [15:0] t_refi_m1 = 16'd99;
    logic [3:0]  t_gap_m1 = 4'd1;
    logic        idle = 1'b0;
    logic [3:0]  debt;
    logic        urgent;
    logic        overflow;
    int          n_tests = 0;
    int          n_fail = 0;

    sal_ref_sched_if #(.NUM_BANKS(8)) bus ();

    sal_ref_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_en_i    (ref_en),
        .t_refi_m1_i (t_refi_m1),
        .t_gap_m1_i  (t_gap_m1),
        .idle_i      (idle),
        .ref_if      (bus),
        .debt_o      (debt),
        .urgent_o    (urgent),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int refi, input int gap);
        rst_n       = 1'b0;
        ref_en      = 1'b0;
        idle        = 1'b0;
        bus.ref_gnt = '0;
        t_refi_m1   = 16'(refi);
        t_gap_m1    = 4'(gap);
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(99, 1);
        n_tests++; if (bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL reset_req: got %h exp 00", bus.ref_req); end
        n_tests++; if (debt !== 4'd0) begin n_fail++; $display("FAIL reset_debt: got %0d exp 0", debt); end
        n_tests++; if (urgent !== 1'b0) begin n_fail++; $display("FAIL reset_urgent: got %b exp 0", urgent); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp;
        do_reset(99, 1);
        ref_en = 1'b1;
        step(99);
        n_tests++; if (bus.ref_req !== 8'h00 || debt !== 4'd0) begin n_fail++; $display("FAIL rr_pre_tick: req %h debt %0d exp 00/0", bus.ref_req, debt); end
        step(1);
        for (int b = 0; b < 9; b++) begin
            exp = 8'h01 << (b % 8);
            n_tests++; if (bus.ref_req !== exp || debt !== 4'd1) begin n_fail++; $display("FAIL rr_req b%0d: req %h debt %0d exp %h/1", b, bus.ref_req, debt, exp); end
            step(2);
            bus.ref_gnt = exp;
            step(1);
            bus.ref_gnt = '0;
            n_tests++; if (bus.ref_req !== 8'h00 || debt !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rr_gnt b%0d: req %h debt %0d ovf %b exp 00/0/0", b, bus.ref_req, debt, overflow); end
            step(97);
        end
    endtask

    task automatic test_saturation;
        do_reset(9, 1);
        ref_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(10);
            n_tests++; if (debt !== 4'(k) || urgent !== (k >= 6) || overflow !== 1'b0 || bus.ref_req !== 8'h01) begin
                n_fail++; $display("FAIL sat_debt k%0d: debt %0d urg %b ovf %b req %h exp %0d/%b/0/01", k, debt, urgent, overflow, bus.ref_req, k, (k >= 6));
            end
        end
        step(9);
        bus.ref_gnt = 8'h01;
        step(1);
        bus.ref_gnt = '0;
        n_tests++; if (debt !== 4'd8 || overflow !== 1'b0 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL sat_collide: debt %0d ovf %b req %h exp 8/0/00", debt, overflow, bus.ref_req); end
        step(10);
        n_tests++; if (overflow !== 1'b1 || debt !== 4'd8) begin n_fail++; $display("FAIL sat_overflow: ovf %b debt %0d exp 1/8", overflow, debt); end
        step(20);
        n_tests++; if (overflow !== 1'b1 || bus.ref_req !== 8'h02) begin n_fail++; $display("FAIL sat_sticky: ovf %b req %h exp 1/02", overflow, bus.ref_req); end
        bus.ref_gnt = 8'h02;
        step(1);
        bus.ref_gnt = '0;
        n_tests++; if (debt !== 4'd7 || bus.ref_req !== 8'h00 || urgent !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt: debt %0d req %h urg %b exp 7/00/1", debt, bus.ref_req, urgent); end
        step(1);
        n_tests++; if (bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL b2b_gap: req %h exp 00", bus.ref_req); end
        step(1);
        n_tests++; if (bus.ref_req !== 8'h04) begin n_fail++; $display("FAIL b2b_next: req %h exp 04", bus.ref_req); end
    endtask

    task automatic test_tick_grant_collide;
        do_reset(9, 0);
        ref_en = 1'b1;
        step(30);
        n_tests++; if (debt !== 4'd3 || bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL col_pre: debt %0d req %h exp 3/01", debt, bus.ref_req); end
        step(9);
        bus.ref_gnt = 8'h01;
        step(1);
        bus.ref_gnt = '0;
        n_tests++; if (debt !== 4'd3 || bus.ref_req !== 8'h00 || urgent !== 1'b0) begin n_fail++; $display("FAIL col_same: debt %0d req %h urg %b exp 3/00/0", debt, bus.ref_req, urgent); end
        step(1);
        n_tests++; if (debt !== 4'd3 || bus.ref_req !== 8'h02) begin n_fail++; $display("FAIL col_ptr: debt %0d req %h exp 3/02", debt, bus.ref_req); end
    endtask

    task automatic test_wrong_bank;
        do_reset(9, 1);
        ref_en = 1'b1;
        bus.ref_gnt = 8'hFF;
        step(5);
        n_tests++; if (debt !== 4'd0 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL wb_idle: debt %0d req %h exp 0/00", debt, bus.ref_req); end
        bus.ref_gnt = '0;
        step(5);
        bus.ref_gnt = 8'hFE;
        step(3);
        n_tests++; if (debt !== 4'd1 || bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL wb_other: debt %0d req %h exp 1/01", debt, bus.ref_req); end
        bus.ref_gnt = 8'h01;
        step(1);
        n_tests++; if (debt !== 4'd0 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL wb_right: debt %0d req %h exp 0/00", debt, bus.ref_req); end
        bus.ref_gnt = 8'hFF;
        step(2);
        n_tests++; if (debt !== 4'd0 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL wb_gap: debt %0d req %h exp 0/00", debt, bus.ref_req); end
        bus.ref_gnt = '0;
        step(4);
        n_tests++; if (debt !== 4'd1 || bus.ref_req !== 8'h02) begin n_fail++; $display("FAIL wb_next: debt %0d req %h exp 1/02", debt, bus.ref_req); end
    endtask

    task automatic test_enable_drop;
        do_reset(9, 1);
        ref_en = 1'b1;
        step(20);
        n_tests++; if (debt !== 4'd2 || bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL en_pre: debt %0d req %h exp 2/01", debt, bus.ref_req); end
        ref_en = 1'b0;
        step(1);
        n_tests++; if (debt !== 4'd2 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL en_drop: debt %0d req %h exp 2/00", debt, bus.ref_req); end
        step(15);
        n_tests++; if (debt !== 4'd2 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL en_hold: debt %0d req %h exp 2/00", debt, bus.ref_req); end
        ref_en = 1'b1;
        step(1);
        n_tests++; if (bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL en_resume: req %h exp 01", bus.ref_req); end
        step(9);
        n_tests++; if (debt !== 4'd3) begin n_fail++; $display("FAIL en_reload: debt %0d exp 3", debt); end
    endtask

    task automatic test_reset_mid;
        do_reset(9, 1);
        ref_en = 1'b1;
        step(10);
        bus.ref_gnt = 8'h01;
        rst_n = 1'b0;
        step(1);
        n_tests++; if (debt !== 4'd0 || bus.ref_req !== 8'h00 || urgent !== 1'b0) begin n_fail++; $display("FAIL rst_mid: debt %0d req %h urg %b exp 0/00/0", debt, bus.ref_req, urgent); end
        rst_n = 1'b1;
        bus.ref_gnt = '0;
        step(10);
        n_tests++; if (debt !== 4'd1 || bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL rst_after: debt %0d req %h exp 1/01", debt, bus.ref_req); end
    endtask

`ifdef SAL_REF_PULL_IN_EN
    task automatic test_pull_in;
        logic [7:0] exp;
        do_reset(49, 0);
        ref_en = 1'b1;
        idle   = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) begin
            exp = 8'h01 << i;
            n_tests++; if (bus.ref_req !== exp || debt !== 4'd0) begin n_fail++; $display("FAIL pi_req %0d: req %h debt %0d exp %h/0", i, bus.ref_req, debt, exp); end
            bus.ref_gnt = exp;
            step(1);
            bus.ref_gnt = '0;
            step(2);
        end
        step(1);
        n_tests++; if (bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL pi_full: req %h exp 00", bus.ref_req); end
        idle = 1'b0;
        step(24);
        for (int k = 1; k <= 8; k++) begin
            n_tests++; if (debt !== 4'd0 || bus.ref_req !== 8'h00) begin n_fail++; $display("FAIL pi_tick %0d: debt %0d req %h exp 0/00", k, debt, bus.ref_req); end
            step(50);
        end
        n_tests++; if (debt !== 4'd1 || bus.ref_req !== 8'h01) begin n_fail++; $display("FAIL pi_spent: debt %0d req %h exp 1/01", debt, bus.ref_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_saturation();
        test_tick_grant_collide();
        test_wrong_bank();
        test_enable_drop();
        test_reset_mid();
`ifdef SAL_REF_PULL_IN_EN
        test_pull_in();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
